// File: rtl/pll_lock_supervisor_pkg.sv
// Shared types and helpers for the PLL lock supervisor.
// Also holds the counter-sizing function used by the top.
package pll_lock_supervisor_pkg;

  typedef enum logic [2:0] {
    PLL_RESET,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAIL
  } state_e;

  // Bits needed to hold values 0..n-1; never less than one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single control bit.
// Resets to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, waits for stable lock, then releases the system reset.
// Retries on lock timeout, gives up after MAX_RETRIES, and counts lock losses.
module pll_lock_supervisor
  import pll_lock_supervisor_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pll_locked,
  input  logic             force_relock,
  output logic             pll_rst,
  output logic             sys_rst,
  output logic             ready,
  output logic             fail,
  output logic [CNT_W-1:0] relock_count
);

  localparam int MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAXC  = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
  localparam int CW    = clog2(MAXC);
  localparam int RW    = clog2(MAX_RETRIES + 1);

  state_e        state, nxt;
  logic [CW-1:0] cnt;
  logic [RW-1:0] retry;
  logic          locked_s;
  logic          timeout;
  logic          lock_lost;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

  // Lock wins over a coincident timeout; force_relock wins over everything.
  assign timeout   = (state == WAIT_LOCK) && !locked_s && (cnt == CW'(LOCK_TIMEOUT - 1));
  assign lock_lost = (state == RUN) && !locked_s;

  always_comb begin
    nxt = state;
    if (force_relock) begin
      nxt = PLL_RESET;
    end else begin
      case (state)
        PLL_RESET: if (cnt == CW'(RST_CYCLES - 1)) nxt = WAIT_LOCK;
        WAIT_LOCK: begin
          if (locked_s)
            nxt = STABLE;
          else if (timeout)
            nxt = (retry + 1'b1 == RW'(MAX_RETRIES)) ? FAIL : PLL_RESET;
        end
        STABLE: begin
          if (!locked_s)
            nxt = WAIT_LOCK;
          else if (cnt == CW'(STABLE_CYCLES - 1))
            nxt = RUN;
        end
        RUN:     if (!locked_s) nxt = WAIT_LOCK;
        default: nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= PLL_RESET;
      cnt          <= '0;
      retry        <= '0;
      pll_rst      <= 1'b1;
      sys_rst      <= 1'b1;
      ready        <= 1'b0;
      fail         <= 1'b0;
      relock_count <= '0;
    end else begin
      state <= nxt;
      cnt   <= (nxt != state || force_relock) ? '0 : cnt + 1'b1;

      if (force_relock || nxt == RUN)
        retry <= '0;
      else if (timeout)
        retry <= retry + 1'b1;

      if (!force_relock && lock_lost && relock_count != {CNT_W{1'b1}})
        relock_count <= relock_count + 1'b1;

      // Outputs decode the state being entered, so they line up with it.
      pll_rst <= (nxt == PLL_RESET);
      sys_rst <= (nxt != RUN);
      ready   <= (nxt == RUN);
      fail    <= (nxt == FAIL);
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with a scoreboard of expected values.
// Timing measurements are taken 1 time unit after each rising clock edge.
module tb_pll_lock_supervisor;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 20;
  localparam int STABLE_CYCLES = 8;
  localparam int MAX_RETRIES   = 2;
  localparam int CNT_W         = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             pll_locked = 1'b0;
  logic             force_relock = 1'b0;
  logic             pll_rst, sys_rst, ready, fail;
  logic [CNT_W-1:0] relock_count;

  pll_lock_supervisor #(
    .RST_CYCLES    (RST_CYCLES),
    .LOCK_TIMEOUT  (LOCK_TIMEOUT),
    .STABLE_CYCLES (STABLE_CYCLES),
    .MAX_RETRIES   (MAX_RETRIES),
    .CNT_W         (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .force_relock (force_relock),
    .pll_rst      (pll_rst),
    .sys_rst      (sys_rst),
    .ready        (ready),
    .fail         (fail),
    .relock_count (relock_count)
  );

  always #10 clk = ~clk;

  typedef struct {
    string tag;
    int    exp;
  } exp_t;

  exp_t sbq[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Packs {pll_rst, sys_rst, ready, fail, relock_count} into one number.
  function automatic int pk(input bit pr, input bit sr, input bit rd, input bit fl, input int c);
    return (int'(pr) << 7) | (int'(sr) << 6) | (int'(rd) << 5) | (int'(fl) << 4) | (c & 15);
  endfunction

  function automatic int outs();
    return pk(pll_rst, sys_rst, ready, fail, int'(relock_count));
  endfunction

  task automatic expect_val(input string tag, input int e);
    sbq.push_back('{tag, e});
  endtask

  task automatic compare(input int obs);
    exp_t x;
    vectors++;
    if (sbq.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty: got %0d with no expected entry", obs);
      return;
    end
    x = sbq.pop_front();
    assert (obs === x.exp) else begin
      miscompares++;
      $error("FAIL %s: got %0d expected %0d", x.tag, obs, x.exp);
    end
  endtask

  // Length of the next pll_rst high pulse, starting at the current sample.
  task automatic pll_rst_pulse(output int w);
    int t;
    t = 0;
    w = 0;
    while (!pll_rst && t < 200) begin step(1); t++; end
    while (pll_rst && w < 200) begin step(1); w++; end
  endtask

  task automatic pll_rst_low(output int w);
    w = 0;
    while (!pll_rst && w < 200) begin step(1); w++; end
  endtask

  // Cycles until sys_rst equals lvl (-1 on timeout); flags any pll_rst pulse.
  task automatic sys_rst_wait(input logic lvl, output int n, output int pr_seen);
    n = 0;
    pr_seen = 0;
    while (sys_rst !== lvl && n < 200) begin
      step(1);
      n++;
      if (pll_rst) pr_seen = 1;
    end
    if (sys_rst !== lvl) n = -1;
  endtask

  task automatic fail_wait(output int n);
    n = 0;
    while (fail !== 1'b1 && n < 200) begin step(1); n++; end
    if (fail !== 1'b1) n = -1;
  endtask

  task automatic do_reset(input logic lock);
    pll_locked = lock;
    force_relock = 1'b0;
    rst = 1'b1;
    step(2);
    expect_val("reset_outputs", pk(1, 1, 0, 0, 0));
    compare(outs());
    rst = 1'b0;
  endtask

  // One-cycle lock drop while in RUN; expects the relock count afterwards.
  task automatic lose_lock(input int exp_cnt);
    int n, pr;
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    expect_val("loss_sys_rst_delay", 2);
    sys_rst_wait(1'b1, n, pr);
    compare(n);
    expect_val("loss_outputs", pk(0, 1, 0, 0, exp_cnt));
    compare(outs());
    expect_val("loss_relock_to_run", 1 + STABLE_CYCLES);
    sys_rst_wait(1'b0, n, pr);
    compare(n);
    expect_val("loss_no_pll_rst", 0);
    compare(pr);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, pr;

    // Nominal lock
    do_reset(1'b1);
    expect_val("nom_pll_rst_width", RST_CYCLES);
    pll_rst_pulse(n);
    compare(n);
    expect_val("nom_to_run", 1 + STABLE_CYCLES);
    sys_rst_wait(1'b0, n, pr);
    compare(n);
    expect_val("nom_run_outputs", pk(0, 0, 1, 0, 0));
    compare(outs());

    // One timeout, then lock
    do_reset(1'b0);
    expect_val("retry_pulse1", RST_CYCLES);
    pll_rst_pulse(n);
    compare(n);
    expect_val("retry_wait_len", LOCK_TIMEOUT);
    pll_rst_low(n);
    compare(n);
    expect_val("retry_pulse2", RST_CYCLES);
    pll_rst_pulse(n);
    compare(n);
    step(2);
    pll_locked = 1'b1;
    // 2 sync cycles + 1 WAIT_LOCK decision + STABLE
    expect_val("retry_to_run", 3 + STABLE_CYCLES);
    sys_rst_wait(1'b0, n, pr);
    compare(n);
    expect_val("retry_run_outputs", pk(0, 0, 1, 0, 0));
    compare(outs());

    // Retry count cleared in RUN: a single later timeout must not reach FAIL
    pll_locked = 1'b0;
    expect_val("run_loss_delay", 3);
    sys_rst_wait(1'b1, n, pr);
    compare(n);
    expect_val("run_loss_wait_len", LOCK_TIMEOUT);
    pll_rst_low(n);
    compare(n);
    expect_val("run_loss_retry_pulse", RST_CYCLES);
    pll_rst_pulse(n);
    compare(n);
    expect_val("retry_cleared_outputs", pk(0, 1, 0, 0, 1));
    compare(outs());

    // Retries exhausted
    do_reset(1'b0);
    expect_val("fail_pulse1", RST_CYCLES);
    pll_rst_pulse(n);
    compare(n);
    expect_val("fail_wait1", LOCK_TIMEOUT);
    pll_rst_low(n);
    compare(n);
    expect_val("fail_pulse2", RST_CYCLES);
    pll_rst_pulse(n);
    compare(n);
    expect_val("fail_wait2", LOCK_TIMEOUT);
    fail_wait(n);
    compare(n);
    expect_val("fail_outputs", pk(0, 1, 0, 1, 0));
    compare(outs());
    pll_locked = 1'b1;
    step(20);
    expect_val("fail_ignores_lock", pk(0, 1, 0, 1, 0));
    compare(outs());

    // force_relock out of FAIL
    force_relock = 1'b1;
    step(1);
    force_relock = 1'b0;
    expect_val("force_fail_outputs", pk(1, 1, 0, 0, 0));
    compare(outs());
    expect_val("force_fail_pulse", RST_CYCLES);
    pll_rst_pulse(n);
    compare(n);
    expect_val("force_fail_to_run", 1 + STABLE_CYCLES);
    sys_rst_wait(1'b0, n, pr);
    compare(n);

    // force_relock inside PLL_RESET restarts the pulse
    do_reset(1'b1);
    step(2);
    force_relock = 1'b1;
    step(1);
    force_relock = 1'b0;
    expect_val("force_restart_pulse", RST_CYCLES);
    pll_rst_pulse(n);
    compare(n);

    // Glitch after 5 stable cycles
    step(5);
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    // 2 sync cycles to see the low, 1 to WAIT_LOCK, 1 back to STABLE, 8 stable, less the one already taken
    expect_val("glitch_to_run", 3 + STABLE_CYCLES);
    sys_rst_wait(1'b0, n, pr);
    compare(n);
    expect_val("glitch_no_pll_rst", 0);
    compare(pr);

    // Lock losses in RUN
    for (int k = 1; k <= 3; k++) lose_lock(k);

    // force_relock coincident with a lock loss in RUN
    pll_locked = 1'b0;
    step(2);
    force_relock = 1'b1;
    pll_locked = 1'b1;
    step(1);
    force_relock = 1'b0;
    expect_val("coinc_outputs", pk(1, 1, 0, 0, 3));
    compare(outs());
    expect_val("coinc_pulse", RST_CYCLES);
    pll_rst_pulse(n);
    compare(n);
    expect_val("coinc_to_run", 1 + STABLE_CYCLES);
    sys_rst_wait(1'b0, n, pr);
    compare(n);

    // Run the count up to saturation and one beyond
    for (int k = 4; k <= 16; k++) lose_lock((k > 15) ? 15 : k);

    // Asynchronous reset mid-operation
    rst = 1'b1;
    #2;
    expect_val("async_reset_outputs", pk(1, 1, 0, 0, 0));
    compare(outs());
    step(1);
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
